// File: rtl/ram_req_arb_if.sv
// Bundle of the two master request/response channels and the RAM port.
// The arbiter takes the slave side; whatever drives masters and models the RAM
// takes the master side.
interface ram_req_arb_if #(
  parameter int abits = 12,
  parameter int dbits = 64
);
  logic             i_m0_req_valid;
  logic             o_m0_req_ready;
  logic             i_m0_req_write;
  logic [abits-1:0] i_m0_req_addr;
  logic [dbits-1:0] i_m0_req_wdata;
  logic             o_m0_resp_valid;
  logic             i_m0_resp_ready;
  logic [dbits-1:0] o_m0_resp_rdata;

  logic             i_m1_req_valid;
  logic             o_m1_req_ready;
  logic             i_m1_req_write;
  logic [abits-1:0] i_m1_req_addr;
  logic [dbits-1:0] i_m1_req_wdata;
  logic             o_m1_resp_valid;
  logic             i_m1_resp_ready;
  logic [dbits-1:0] o_m1_resp_rdata;

  logic [abits-1:0] o_ram_addr;
  logic             o_ram_wena;
  logic [dbits-1:0] o_ram_wdata;
  logic [dbits-1:0] i_ram_rdata;

  modport slave (
    input  i_m0_req_valid, i_m0_req_write, i_m0_req_addr, i_m0_req_wdata, i_m0_resp_ready,
    output o_m0_req_ready, o_m0_resp_valid, o_m0_resp_rdata,
    input  i_m1_req_valid, i_m1_req_write, i_m1_req_addr, i_m1_req_wdata, i_m1_resp_ready,
    output o_m1_req_ready, o_m1_resp_valid, o_m1_resp_rdata,
    output o_ram_addr, o_ram_wena, o_ram_wdata,
    input  i_ram_rdata
  );

  modport master (
    output i_m0_req_valid, i_m0_req_write, i_m0_req_addr, i_m0_req_wdata, i_m0_resp_ready,
    input  o_m0_req_ready, o_m0_resp_valid, o_m0_resp_rdata,
    output i_m1_req_valid, i_m1_req_write, i_m1_req_addr, i_m1_req_wdata, i_m1_resp_ready,
    input  o_m1_req_ready, o_m1_resp_valid, o_m1_resp_rdata,
    input  o_ram_addr, o_ram_wena, o_ram_wdata,
    output i_ram_rdata
  );
endinterface

// File: rtl/ram_req_arb.sv
// Two-master front end for the single-port RAM wrapper: round-robin grant of
// one request per cycle, and a one-entry response register per master so each
// master can stall its read data independently.

// Per-master read tracking: in-flight flag plus the response holding register.
module ram_req_arb_lane #(
  parameter int dbits = 64
) (
  input  logic             i_clk,
  input  logic             i_nrst,
  input  logic             i_req_valid,
  input  logic             i_req_write,
  input  logic             i_grant,
  input  logic             i_resp_ready,
  input  logic [dbits-1:0] i_ram_rdata,
  output logic             o_elig,
  output logic             o_resp_valid,
  output logic [dbits-1:0] o_resp_rdata
);
  logic             inflight_q, inflight_d;
  logic             resp_valid_q, resp_valid_d;
  logic [dbits-1:0] rdata_q, rdata_d;

  // A read may only issue when nothing is in flight and the response slot is
  // free, or is being drained this cycle, so the returning data always lands.
  assign o_elig = i_req_valid &
                  (i_req_write | (~inflight_q & (~resp_valid_q | i_resp_ready)));

  // Next state: mark granted reads in flight; capture RAM data a cycle later.
  always_comb begin
    inflight_d   = i_grant & ~i_req_write;
    resp_valid_d = resp_valid_q;
    rdata_d      = rdata_q;
    if (resp_valid_q && i_resp_ready) resp_valid_d = 1'b0;
    // A load in the same cycle as a drain wins.
    if (inflight_q) begin
      resp_valid_d = 1'b1;
      rdata_d      = i_ram_rdata;
    end
  end

  // State registers; reset drops any in-flight read and pending response.
  always_ff @(posedge i_clk or negedge i_nrst) begin
    if (!i_nrst) begin
      inflight_q   <= 1'b0;
      resp_valid_q <= 1'b0;
      rdata_q      <= '0;
    end else begin
      inflight_q   <= inflight_d;
      resp_valid_q <= resp_valid_d;
      rdata_q      <= rdata_d;
    end
  end

  assign o_resp_valid = resp_valid_q;
  assign o_resp_rdata = rdata_q;
endmodule

module ram_req_arb #(
  parameter int abits = 12,
  parameter int dbits = 64
) (
  input logic          i_clk,
  input logic          i_nrst,
  ram_req_arb_if.slave bus
);
  localparam int NUM_M = 2;

  logic [NUM_M-1:0]            req_valid, req_write, resp_ready;
  logic [NUM_M-1:0]            elig, grant, resp_valid;
  logic [NUM_M-1:0][abits-1:0] req_addr;
  logic [NUM_M-1:0][dbits-1:0] req_wdata, resp_rdata;
  logic                        ptr_q, ptr_d;   // 0: m0 wins a tie
  logic                        gsel, any_grant;

  assign req_valid  = {bus.i_m1_req_valid,  bus.i_m0_req_valid};
  assign req_write  = {bus.i_m1_req_write,  bus.i_m0_req_write};
  assign req_addr   = {bus.i_m1_req_addr,   bus.i_m0_req_addr};
  assign req_wdata  = {bus.i_m1_req_wdata,  bus.i_m0_req_wdata};
  assign resp_ready = {bus.i_m1_resp_ready, bus.i_m0_resp_ready};

  for (genvar k = 0; k < NUM_M; k++) begin : g_lane
    ram_req_arb_lane #(.dbits(dbits)) u_lane (
      .i_clk        (i_clk),
      .i_nrst       (i_nrst),
      .i_req_valid  (req_valid[k]),
      .i_req_write  (req_write[k]),
      .i_grant      (grant[k]),
      .i_resp_ready (resp_ready[k]),
      .i_ram_rdata  (bus.i_ram_rdata),
      .o_elig       (elig[k]),
      .o_resp_valid (resp_valid[k]),
      .o_resp_rdata (resp_rdata[k])
    );
  end

  // Grant: a lone eligible master wins, a tie goes to the pointer. Gated by
  // reset so the RAM port and ready outputs drop immediately on reset.
  always_comb begin
    grant = '0;
    if (i_nrst) begin
      if (&elig) grant[ptr_q] = 1'b1;
      else       grant        = elig;
    end
  end

  assign any_grant = |grant;
  assign gsel      = grant[1];

  // Pointer hands priority to the other master after every grant.
  always_comb begin
    ptr_d = ptr_q;
    if (any_grant) ptr_d = ~gsel;
  end

  // Round-robin pointer register.
  always_ff @(posedge i_clk or negedge i_nrst) begin
    if (!i_nrst) ptr_q <= 1'b0;
    else         ptr_q <= ptr_d;
  end

  assign bus.o_ram_addr  = any_grant ? req_addr[gsel]  : '0;
  assign bus.o_ram_wdata = any_grant ? req_wdata[gsel] : '0;
  assign bus.o_ram_wena  = any_grant & req_write[gsel];

  assign bus.o_m0_req_ready  = grant[0];
  assign bus.o_m1_req_ready  = grant[1];
  assign bus.o_m0_resp_valid = resp_valid[0];
  assign bus.o_m1_resp_valid = resp_valid[1];
  assign bus.o_m0_resp_rdata = resp_rdata[0];
  assign bus.o_m1_resp_rdata = resp_rdata[1];
endmodule
